// File: rtl/aes_serial_feeder.sv
// Serial feeder for the bit-serial AES core: accepts one block/key/direction, streams both MSB first.
// Optional watchdog on the done wait is enabled by defining AES_FEED_WDOG_EN.
module aes_serial_feeder #(
  parameter int DATA_W      = 128,
  parameter int KEY_W       = 128,
  parameter int WDOG_CYCLES = 4096
) (
  input  logic              io_clk,
  input  logic              io_reset,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic [KEY_W-1:0]  s_key,
  input  logic              s_decrypt,
  output logic              io_dataIn_bit,
  output logic              io_key_bit,
  output logic              io_start,
  output logic              io_decrypt,
  input  logic              io_done,
  output logic              feeder_busy
`ifdef AES_FEED_WDOG_EN
  ,
  output logic              wdog_err
`endif
);

  localparam int N     = (DATA_W > KEY_W) ? DATA_W : KEY_W;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SHIFT     = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] data_sr;
  logic [KEY_W-1:0]  key_sr;

  if (WDOG_CYCLES < 2) begin : g_wdog_param_check
    $error("WDOG_CYCLES must be at least 2");
  end

`ifdef AES_FEED_WDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYCLES - 1);
  logic [WD_W-1:0] wd_cnt;
`endif

  // NOTE: state is updated with non-blocking assignments only, so every reader in this
  // clock domain sees the pre-edge value regardless of block ordering.
  always_ff @(posedge io_clk) begin
    if (io_reset) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      io_start   <= 1'b0;
      io_decrypt <= 1'b0;
`ifdef AES_FEED_WDOG_EN
      wd_cnt     <= '0;
      wdog_err   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (s_valid) begin
            state      <= SHIFT;
            bit_cnt    <= '0;
            io_start   <= 1'b1;
            io_decrypt <= s_decrypt;
`ifdef AES_FEED_WDOG_EN
            wdog_err   <= 1'b0;
`endif
          end
        end
        SHIFT: begin
          io_start <= 1'b0;
          bit_cnt  <= bit_cnt + CNT_W'(1);
          if (bit_cnt == CNT_LAST) begin
            state   <= WAIT_DONE;
            bit_cnt <= '0;
`ifdef AES_FEED_WDOG_EN
            wd_cnt  <= '0;
`endif
          end
        end
        WAIT_DONE: begin
          // A done pulse on the terminal watchdog cycle still counts as completion.
          if (io_done) begin
            state      <= IDLE;
            io_decrypt <= 1'b0;
          end
`ifdef AES_FEED_WDOG_EN
          else if (wd_cnt == WD_LAST) begin
            state      <= IDLE;
            io_decrypt <= 1'b0;
            wdog_err   <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the operand shift registers carry no reset; the serial outputs are gated by
  // state, so stale contents never reach the core before a fresh load.
  always_ff @(posedge io_clk) begin
    if (state == IDLE && s_valid) begin
      data_sr <= s_data;
      key_sr  <= s_key;
    end else if (state == SHIFT) begin
      // Zeros shift in behind the narrower operand, which then drives 0 after its last bit.
      data_sr <= data_sr << 1;
      key_sr  <= key_sr << 1;
    end
  end

  assign s_ready       = (state == IDLE);
  assign feeder_busy   = (state != IDLE);
  assign io_dataIn_bit = (state == SHIFT) & data_sr[DATA_W-1];
  assign io_key_bit    = (state == SHIFT) & key_sr[KEY_W-1];

endmodule

// File: tb/tb_aes_serial_feeder.sv
// Directed bench for aes_serial_feeder: reset, encrypt/decrypt streams, done handshake,
// mid-stream reset and (with AES_FEED_WDOG_EN) the watchdog abort.
module tb_aes_serial_feeder;

  localparam int DW = 128;
  localparam int KW = 128;
`ifdef AES_FEED_WDOG_EN
  localparam int WD = 16;
`else
  localparam int WD = 4096;
`endif

  logic          io_clk;
  logic          io_reset;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic [KW-1:0] s_key;
  logic          s_decrypt;
  logic          io_dataIn_bit;
  logic          io_key_bit;
  logic          io_start;
  logic          io_decrypt;
  logic          io_done;
  logic          feeder_busy;
`ifdef AES_FEED_WDOG_EN
  logic          wdog_err;
`endif

  aes_serial_feeder #(.DATA_W(DW), .KEY_W(KW), .WDOG_CYCLES(WD)) dut (
    .io_clk        (io_clk),
    .io_reset      (io_reset),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_data        (s_data),
    .s_key         (s_key),
    .s_decrypt     (s_decrypt),
    .io_dataIn_bit (io_dataIn_bit),
    .io_key_bit    (io_key_bit),
    .io_start      (io_start),
    .io_decrypt    (io_decrypt),
    .io_done       (io_done),
    .feeder_busy   (feeder_busy)
`ifdef AES_FEED_WDOG_EN
    ,
    .wdog_err      (wdog_err)
`endif
  );

  initial io_clk = 1'b0;
  always #5 io_clk = ~io_clk;

  int tests = 0;
  int fails = 0;

  localparam logic [127:0] D1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] D2 = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] D3 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] K3 = 128'hffffffff00000000a5a5a5a55a5a5a5a;
  localparam logic [127:0] D4 = 128'h80000000000000000000000000000001;
  localparam logic [127:0] K4 = 128'h55aa55aa55aa55aa0123456789abcdef;

  // {s_ready, io_dataIn_bit, io_key_bit, io_start, io_decrypt, feeder_busy}
  localparam logic [5:0] IDLE_VEC = 6'b100000;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge io_clk);
    #1;
  endtask

  function automatic logic [5:0] out_vec();
    return {s_ready, io_dataIn_bit, io_key_bit, io_start, io_decrypt, feeder_busy};
  endfunction

  task automatic handshake(input logic [127:0] d, input logic [127:0] k, input logic dec);
    s_valid   = 1'b1;
    s_data    = d;
    s_key     = k;
    s_decrypt = dec;
    check("hs_ready", s_ready, 1'b1);
    tick();
    s_valid = 1'b0;
  endtask

  // Called in the first cycle after the accepting edge. Collects the serial bits for
  // N cycles (or up to abort_k, where reset is raised without advancing the clock).
  task automatic stream(input string tag, input logic [127:0] d, input logic [127:0] k,
                        input logic dec, input int done_k, input int abort_k);
    logic [127:0] got_d;
    logic [127:0] got_k;
    logic [127:0] mask;
    bit           dec_ok;
    bit           busy_ok;
    int           n;
    got_d   = '0;
    got_k   = '0;
    dec_ok  = 1'b1;
    busy_ok = 1'b1;
    n       = 128;
    for (int kk = 0; kk < 128; kk++) begin
      if (kk == abort_k) begin
        io_reset = 1'b1;
        n = kk;
        break;
      end
      if (kk == 0) begin
        check({tag, "_start_k0"}, io_start, 1'b1);
        check({tag, "_ready_k0"}, s_ready, 1'b0);
      end
      if (kk == 1) check({tag, "_start_k1"}, io_start, 1'b0);
      got_d[127-kk] = io_dataIn_bit;
      got_k[127-kk] = io_key_bit;
      if (io_decrypt !== dec) dec_ok = 1'b0;
      if (feeder_busy !== 1'b1) busy_ok = 1'b0;
      io_done = (kk == done_k);
      tick();
    end
    io_done = 1'b0;
    mask = (n == 0) ? 128'h0 : ({128{1'b1}} << (128 - n));
    check({tag, "_data_bits"}, got_d & mask, d & mask);
    check({tag, "_key_bits"}, got_k & mask, k & mask);
    check({tag, "_decrypt_steady"}, dec_ok, 1'b1);
    check({tag, "_busy_steady"}, busy_ok, 1'b1);
  endtask

  initial begin
    io_reset  = 1'b1;
    s_valid   = 1'b0;
    s_data    = '0;
    s_key     = '0;
    s_decrypt = 1'b0;
    io_done   = 1'b0;
    repeat (3) tick();
    io_reset = 1'b0;

    // Reset then idle for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      check("idle_outputs", out_vec(), IDLE_VEC);
      tick();
    end

    // Encrypt stream with a stale done at k=50.
    handshake(D1, K1, 1'b0);
    stream("enc", D1, K1, 1'b0, 50, -1);
    check("enc_wait_outputs", out_vec(), 6'b000001);

    // Core reports done 20 cycles after the last bit; a second block is offered while busy.
    for (int i = 0; i < 19; i++) begin
      if (i == 11) begin
        s_valid   = 1'b1;
        s_data    = D2;
        s_key     = K2;
        s_decrypt = 1'b1;
      end
      tick();
    end
    check("enc_ready_before_done", s_ready, 1'b0);
    check("enc_busy_before_done", feeder_busy, 1'b1);
    io_done = 1'b1;
    tick();
    io_done = 1'b0;
    check("enc_ready_after_done", s_ready, 1'b1);
    check("enc_busy_after_done", feeder_busy, 1'b0);

    // Back-to-back decrypt: s_valid has been held, so the accept is this IDLE cycle.
    tick();
    s_valid = 1'b0;
    stream("dec", D2, K2, 1'b1, -1, -1);
    check("dec_held_in_wait", io_decrypt, 1'b1);
    io_done = 1'b1;
    tick();
    io_done = 1'b0;
    check("dec_idle_outputs", out_vec(), IDLE_VEC);

    // Reset at k=64, with done on the same edge.
    handshake(D3, K3, 1'b0);
    stream("abort", D3, K3, 1'b0, -1, 64);
    io_done = 1'b1;
    tick();
    io_reset = 1'b0;
    io_done  = 1'b0;
    check("abort_post_reset", out_vec(), IDLE_VEC);
    tick();
    check("abort_stays_idle", out_vec(), IDLE_VEC);

    // Fresh block after the abort streams from bit 127 with a new start pulse.
    handshake(D4, K4, 1'b1);
    stream("restart", D4, K4, 1'b1, -1, -1);
    io_done = 1'b1;
    tick();
    io_done = 1'b0;
    check("restart_idle_outputs", out_vec(), IDLE_VEC);

`ifdef AES_FEED_WDOG_EN
    // Watchdog: no done, return to IDLE after 16 WAIT_DONE cycles with a sticky error.
    check("wdog_clear_initially", wdog_err, 1'b0);
    handshake(D1, K1, 1'b0);
    stream("wdog", D1, K1, 1'b0, -1, -1);
    repeat (15) tick();
    check("wdog_busy_last_wait", feeder_busy, 1'b1);
    check("wdog_err_not_yet", wdog_err, 1'b0);
    tick();
    check("wdog_idle_outputs", out_vec(), IDLE_VEC);
    check("wdog_err_set", wdog_err, 1'b1);
    tick();
    check("wdog_err_sticky", wdog_err, 1'b1);
    handshake(D2, K2, 1'b0);
    check("wdog_err_cleared", wdog_err, 1'b0);
    stream("wdog_next", D2, K2, 1'b0, -1, -1);
    io_done = 1'b1;
    tick();
    io_done = 1'b0;
    check("wdog_next_idle", out_vec(), IDLE_VEC);
    check("wdog_next_no_err", wdog_err, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
